dummy_sm_arb: RTL
=================

# dummy_sm_arb

Round-robin arbiter and sequencer that shares one `dummy_sm` instance among `NREQ` requesters. It accepts level requests, grants one requester at a time, and issues the single-cycle `trigger` pulse. It then tracks the machine's `state` through a full IDLE→RUN→WAIT→DONE pass and signals completion back to the granted requester. It sits between the client blocks and `dummy_sm`; only this block drives `dummy_sm.trigger`.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 15, watchdog limit in cycles from trigger to observed DONE (1..255)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NREQ  level request per requester; held until its `gnt` bit rises
- `sm_state`  in  2  `dummy_sm.state` (0 IDLE, 1 RUN, 2 WAIT, 3 DONE)
- `trigger`  out  1  single-cycle start pulse to `dummy_sm`
- `gnt`  out  NREQ  one-hot grant, held for the whole job
- `done`  out  NREQ  one-hot single-cycle completion pulse
- `timeout_err`  out  1  single-cycle pulse when the watchdog fires
- `busy`  out  1  high whenever the arbiter FSM is not in A_IDLE

## Operation
- All outputs are registered. Reset values: `trigger`=0, `gnt`=0, `done`=0, `timeout_err`=0, `busy`=0. FSM resets to A_IDLE; round-robin pointer `ptr` resets to 0; watchdog counter resets to 0.
- FSM states and transitions:
  - A_IDLE: if any `req` bit is set, select the first set bit searching `ptr`, `ptr`+1, …, wrapping mod `NREQ`. Latch it as `win`, assert `gnt[win]`, go to A_FIRE. Otherwise stay.
  - A_FIRE: `trigger`=1 for exactly this cycle. Clear the watchdog. Go to A_WAIT_RUN.
  - A_WAIT_RUN: stay until `sm_state`==RUN, then go to A_TRACK.
  - A_TRACK: stay until `sm_state`==DONE, then go to A_RELEASE.
  - A_RELEASE: pulse `done[win]`, deassert `gnt`, set `ptr`=(`win`+1) mod `NREQ`. Go to A_IDLE.
- Watchdog (macro-gated, see Configuration):
  - Increments every cycle in A_WAIT_RUN and A_TRACK.
  - When it reaches `TIMEOUT`, go to A_RELEASE with `timeout_err`=1 in that cycle. `done[win]` still pulses, `ptr` still advances.
- `req` is sampled only in A_IDLE. If a requester drops `req` after grant, the job is still completed and `done` is still pulsed.
- Simultaneous requests are resolved by pointer order only; there is no fixed priority.
- `sm_state` values other than the awaited value are ignored while waiting, including a premature DONE seen in A_WAIT_RUN.
- Reset asserted mid-job aborts immediately: `gnt`, `trigger` and `done` go to 0 on the next edge, with no `done` pulse.

## Timing
- Request sampled in A_IDLE at cycle N:
  - `gnt` and `busy` high at N+1
  - `trigger` high at N+1 only
- With a healthy `dummy_sm`:
  - `sm_state`=RUN at N+2, WAIT at N+3, DONE at N+4
  - `done` and `timeout_err`-free release at N+5; `gnt` low at N+5
  - FSM back in A_IDLE at N+6
- Minimum grant-to-grant spacing is 6 cycles. Back-to-back requests from different requesters are granted at N+1 and N+7.
- `trigger` is never asserted outside A_FIRE, and never on two consecutive cycles.
- At most one `gnt` bit is high at any time.

## Configuration
- `DUMMY_SM_ARB_TIMEOUT_EN` defined:
  - Watchdog counter present.
  - Jobs are bounded to `TIMEOUT` cycles after A_FIRE.
  - `timeout_err` behaves as described in Operation.
- Not defined:
  - No counter is built; `timeout_err` is tied to 0.
  - A_WAIT_RUN and A_TRACK wait indefinitely for RUN and DONE.

## Test plan
- Single request: `req`=4'b0010 at cycle 0 → `gnt`=4'b0010 and `trigger`=1 at cycle 1; `done`=4'b0010 at cycle 5; `ptr`=2.
- Contention after reset: `req`=4'b1011 held → grants in order 0, 1, 3, 0, each 6 cycles apart; exactly one `trigger` per grant.
- Wrap-around: `ptr`=3, `req`=4'b1001 → requester 3 granted first, then `ptr`=0 and requester 0 granted next.
- Stuck machine, macro defined, `TIMEOUT`=15: force `sm_state`=IDLE after trigger → `timeout_err` and `done[win]` pulse together; FSM returns to A_IDLE; next request served normally.
- Reset mid-job: assert `rst` in A_TRACK → next cycle `gnt`=0, `busy`=0, no `done` pulse; after release of reset, `ptr`=0.
- Early `req` drop: deassert `req` one cycle after grant → job still completes, `done` pulses at cycle 5, and no re-grant follows.

Source files
------------

// File: rtl/dummy_sm_arb_if.sv
// Request/grant bundle between client blocks, the dummy_sm state feed and the dummy_sm_arb arbiter.
interface dummy_sm_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [1:0]      sm_state;
  logic            trigger;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            timeout_err;
  logic            busy;

  modport master (output req, output sm_state, input trigger, input gnt, input done, input timeout_err, input busy);
  modport slave  (input req, input sm_state, output trigger, output gnt, output done, output timeout_err, output busy);
endinterface

// File: rtl/dummy_sm_arb.sv
// Round-robin arbiter/sequencer sharing one dummy_sm among NREQ requesters.
// Define DUMMY_SM_ARB_TIMEOUT_EN to build the trigger-to-DONE watchdog.
module dummy_sm_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst,
  dummy_sm_arb_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int LAST = NREQ - 1;
  localparam logic [PW:0]   NREQ_W = NREQ[PW:0];
  localparam logic [PW-1:0] LAST_W = LAST[PW-1:0];

  localparam logic [2:0] A_IDLE     = 3'd0;
  localparam logic [2:0] A_FIRE     = 3'd1;
  localparam logic [2:0] A_WAIT_RUN = 3'd2;
  localparam logic [2:0] A_TRACK    = 3'd3;
  localparam logic [2:0] A_RELEASE  = 3'd4;

  localparam logic [1:0] SM_RUN  = 2'd1;
  localparam logic [1:0] SM_DONE = 2'd3;

  logic [2:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            trigger_q, trigger_d, busy_q, busy_d;
  logic            release_now;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot, pick_oh, win_oh;
  logic [PW-1:0]     pick_off, pick_idx;
  logic [PW:0]       pick_sum;

`ifdef DUMMY_SM_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_W = TIMEOUT[7:0];
  logic [7:0] wd_q, wd_d;
  logic       tout_q, tout_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  assign req_dbl = {bus.req, bus.req};
  assign req_rot = req_dbl[ptr_q +: NREQ];

  always_comb begin
    pick_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) pick_off = PW'(i);
    end
    pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
    if (pick_sum >= NREQ_W) pick_sum = pick_sum - NREQ_W;
    pick_idx = pick_sum[PW-1:0];
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign pick_oh[gi] = (pick_idx == PW'(gi));
    assign win_oh[gi]  = (win_q == PW'(gi));
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    trigger_d   = 1'b0;
    done_d      = '0;
    release_now = 1'b0;
`ifdef DUMMY_SM_ARB_TIMEOUT_EN
    wd_d   = wd_q;
    tout_d = 1'b0;
`endif
    case (state_q)
      A_IDLE: begin
        if (|bus.req) begin
          win_d     = pick_idx;
          gnt_d     = pick_oh;
          trigger_d = 1'b1;
          state_d   = A_FIRE;
        end
      end
      A_FIRE: begin
        state_d = A_WAIT_RUN;
`ifdef DUMMY_SM_ARB_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      A_WAIT_RUN, A_TRACK: begin
        if (state_q == A_TRACK) release_now = (bus.sm_state == SM_DONE);
        else if (bus.sm_state == SM_RUN) state_d = A_TRACK;
`ifdef DUMMY_SM_ARB_TIMEOUT_EN
        // A DONE arriving on the limit cycle counts as a normal completion.
        wd_d = wd_q + 8'd1;
        if (!release_now && (wd_d == TIMEOUT_W)) begin
          release_now = 1'b1;
          tout_d      = 1'b1;
        end
`endif
        if (release_now) begin
          state_d = A_RELEASE;
          gnt_d   = '0;
          done_d  = win_oh;
        end
      end
      A_RELEASE: begin
        state_d = A_IDLE;
        ptr_d   = (win_q == LAST_W) ? '0 : win_q + 1'b1;
      end
      default: begin
        state_d = A_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != A_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= A_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      trigger_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DUMMY_SM_ARB_TIMEOUT_EN
      wd_q   <= '0;
      tout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      trigger_q <= trigger_d;
      busy_q    <= busy_d;
`ifdef DUMMY_SM_ARB_TIMEOUT_EN
      wd_q   <= wd_d;
      tout_q <= tout_d;
`endif
    end
  end

  assign bus.trigger = trigger_q;
  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
`ifdef DUMMY_SM_ARB_TIMEOUT_EN
  assign bus.timeout_err = tout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule
